universal_shift_reg: RTL and testbench

// - Parameterised universal shift register with four modes: parallel load, shift left, shift right and hold.
// - Serves as a general datapath/display shift element, e.g. LED pattern walking on board I/O.
// - Operates on one clock domain with a synchronous active-low reset.
// - Can optionally be slowed to a human-visible rate by an internal tick prescaler.

---
 rtl/usr_pkg.sv | 19 +
 rtl/usr_tick_prescaler.sv | 45 ++++
 rtl/universal_shift_reg.sv | 83 ++++++++
 tb/tb_universal_shift_reg.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared types and constants for the universal shift register.
//   usr_mode_e    : 2-bit mode select encoding (load / shift left / shift right /
//                   hold), matching the raw encoding on the top-level s port.
//   USR_WIDTH_DEF : default register width.
// -----------------------------------------------------------------------------
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_HOLD = 2'b11
    } usr_mode_e;

    localparam int unsigned USR_WIDTH_DEF = 8;

endpackage : usr_pkg

// File: rtl/usr_tick_prescaler.sv
// -----------------------------------------------------------------------------
// usr_tick_prescaler
// Free-running divider that produces a one-cycle update strobe once every
// DIV_COUNT clocks. It only exists in builds that define USR_TICK_DIV_EN;
// otherwise the shift register updates every clock and this module is not
// compiled at all.
// Parameters:
//   DIV_COUNT : terminal count; the counter runs 0..DIV_COUNT-1 and wraps.
// Ports:
//   clk   in  1  clock, rising edge
//   reset in  1  synchronous, active-low; clears the count
//   tick  out 1  high for one cycle when count == DIV_COUNT-1
// -----------------------------------------------------------------------------
`ifdef USR_TICK_DIV_EN
module usr_tick_prescaler #(
    parameter int unsigned DIV_COUNT = 25000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    // A divide-by-1 still needs a 1-bit counter so the declarations stay legal.
    localparam int unsigned CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : usr_tick_prescaler
`endif

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// WIDTH-bit universal shift register: parallel load, shift left, shift right,
// hold. q is a pure register output (one edge of latency from s/d/sil/sir).
// Optional feature macro: USR_TICK_DIV_EN. When defined, an internal prescaler
// (usr_tick_prescaler, DIV_COUNT parameter) gates updates to one edge in every
// DIV_COUNT; when undefined, tick is tied high, q updates on every clock and
// the DIV_COUNT parameter is not present.
// Parameters:
//   WIDTH     : register width (>= 2)
//   DIV_COUNT : prescaler terminal count (USR_TICK_DIV_EN builds only)
// Ports:
//   clk   in  1      clock, rising edge
//   reset in  1      synchronous, active-low; clears q (and the prescaler)
//   s     in  2      mode: 00 load, 01 shift left, 10 shift right, 11 hold
//   d     in  WIDTH  parallel load data
//   sil   in  1      serial in, enters q[0] on a left shift
//   sir   in  1      serial in, enters q[WIDTH-1] on a right shift
//   q     out WIDTH  register contents
//   tick  out 1      update-enable strobe
// -----------------------------------------------------------------------------
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH     = USR_WIDTH_DEF
`ifdef USR_TICK_DIV_EN
   ,parameter int unsigned DIV_COUNT = 25000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q,
    output logic             tick
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

`ifdef USR_TICK_DIV_EN
    usr_tick_prescaler #(
        .DIV_COUNT (DIV_COUNT)
    ) u_tick_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Mode mux. Inputs are only looked at on tick cycles.
    always_comb begin
        // NOTE: q_d gets a default before any branch so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        q_d = q_q;
        if (tick) begin
            case (usr_mode_e'(s))
                MODE_LOAD: q_d = d;
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], sil};
                MODE_SHR:  q_d = {sir, q_q[WIDTH-1:1]};
                default:   q_d = q_q;   // MODE_HOLD
            endcase
        end
    end

    // Reset is sampled on the clock edge (synchronous) and wins over any mode.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of block ordering.
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
// Self-checking bench for universal_shift_reg (WIDTH=8, USR_TICK_DIV_EN
// undefined). Directed steps cover reset, load, both shift directions with
// zero-fill drain, hold, serial-in and mid-shift reset; a random phase then
// compares q against an arithmetic reference model every edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_universal_shift_reg;

    localparam int W   = 8;
    localparam int MOD = 2 ** W;

    logic         clk;
    logic         reset;
    logic [1:0]   s;
    logic [W-1:0] d;
    logic         sil;
    logic         sir;
    logic [W-1:0] q;
    logic         tick;

    int total = 0;
    int bad   = 0;
    int model_q = 0;   // expected register value, kept as a plain integer

    universal_shift_reg #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .d     (d),
        .sil   (sil),
        .sir   (sir),
        .q     (q),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour expressed as arithmetic on the register value:
    // a left shift doubles and adds the serial bit modulo 2^W, a right shift
    // halves and adds the serial bit weighted by the MSB position.
    function automatic int model_next(input int cur, input logic rst_n, input logic [1:0] mode,
                                      input int din, input int in_l, input int in_r);
        if (!rst_n) return 0;
        case (mode)
            2'd0:    return din;
            2'd1:    return (cur * 2 + in_l) % MOD;
            2'd2:    return cur / 2 + in_r * (MOD / 2);
            default: return cur;
        endcase
    endfunction

    // Apply one clock edge with the currently driven inputs, then compare.
    task automatic step(input string tag);
        model_q = model_next(model_q, reset, s, int'(d), int'(sil), int'(sir));
        @(posedge clk);
        #1;
        check(tag, 32'(q), 32'(model_q));
    endtask

    initial begin
        reset = 1'b0; s = 2'b00; d = 8'hA5; sil = 1'b0; sir = 1'b0;

        // Reset beats a pending load.
        step("reset_q");
        check("reset_q_const", 32'(q), 32'h00);
        check("reset_tick", 32'(tick), 32'h1);

        // Load.
        reset = 1'b1; s = 2'b00; d = 8'hFF;
        step("load_ff");
        check("load_ff_const", 32'(q), 32'hFF);

        // Shift left with zero fill: FE, FC, ... 80, 00, then stays 00.
        s = 2'b01; d = 8'h5A;
        for (int i = 0; i < 10; i++) step($sformatf("shl_%0d", i));
        check("shl_drained", 32'(q), 32'h00);

        // Shift right after reload: 7F, 3F, ... 01, 00.
        s = 2'b00; d = 8'hFF;
        step("reload_ff");
        s = 2'b10;
        for (int i = 0; i < 8; i++) step($sformatf("shr_%0d", i));
        check("shr_drained", 32'(q), 32'h00);

        // Hold keeps a loaded pattern even with d and serial inputs active.
        s = 2'b00; d = 8'h3C;
        step("load_3c");
        s = 2'b11; d = 8'hC3; sil = 1'b1; sir = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("hold_%0d", i));
        check("hold_const", 32'(q), 32'h3C);

        // Serial in on left shift, then reset in the middle of shifting.
        s = 2'b00; d = 8'h00; sil = 1'b0; sir = 1'b0;
        step("clear");
        s = 2'b01; sil = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("sil_%0d", i));
        check("sil_const", 32'(q), 32'h07);
        reset = 1'b0;
        step("mid_reset");
        check("mid_reset_const", 32'(q), 32'h00);
        reset = 1'b1;
        step("resume_after_reset");
        check("resume_const", 32'(q), 32'h01);

        // Serial in on right shift.
        s = 2'b10; sil = 1'b0; sir = 1'b1;
        step("sir_0");
        step("sir_1");
        check("sir_const", 32'(q), 32'hC0);

        // Random phase: modes, data and serial bits change every cycle,
        // with occasional resets.
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 15) != 0);
            s     = 2'($urandom_range(0, 3));
            d     = 8'($urandom);
            sil   = 1'($urandom_range(0, 1));
            sir   = 1'($urandom_range(0, 1));
            step($sformatf("rand_%0d", i));
            check("rand_tick", 32'(tick), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_universal_shift_reg
